// File: rtl/priority_encoder83.sv
// Registered 8-to-3 priority encoder with request latching and acknowledge handshake.
// Pending requests are collected, filtered by a mask and presented highest-priority first.
module priority_encoder83 #(
    parameter bit EDGE_MODE = 1'b1,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [7:0] i_REQ,
    input  logic [7:0] i_MASK,
    input  logic       i_ACK,
    output logic       o_A,
    output logic       o_B,
    output logic       o_C,
    output logic       o_VALID,
    output logic [7:0] o_PENDING
);

    logic [7:0] pending_q;
    logic [7:0] req_d;
    logic [2:0] code_q;
    logic       valid_q;

    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [7:0] pending_next;
    logic [7:0] eligible;
    logic [2:0] code_next;

    // Index of the winning bit; the later hit in the scan overrides earlier ones.
    function automatic logic [2:0] pick(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'b000;
        if (LOW_FIRST) begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 0; i <= 7; i++)
                if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        set_vec      = EDGE_MODE ? (i_REQ & ~req_d) : i_REQ;
        // An ACK only retires something while a code is actually being presented.
        clr_vec      = (i_ACK && valid_q) ? (8'b0000_0001 << code_q) : 8'b0000_0000;
        // Set is OR-ed in last so a simultaneous set and clear keeps the bit pending.
        pending_next = (pending_q & ~clr_vec) | set_vec;
        eligible     = pending_next & i_MASK;
        code_next    = pick(eligible);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            pending_q <= 8'h00;
            req_d     <= 8'h00;
            code_q    <= 3'b000;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_next;
            req_d     <= i_REQ;
            code_q    <= code_next;
            valid_q   <= |eligible;
        end
    end

    assign o_A       = code_q[2];
    assign o_B       = code_q[1];
    assign o_C       = code_q[0];
    assign o_VALID   = valid_q;
    assign o_PENDING = pending_q;

endmodule

// File: tb/tb_priority_encoder83.sv
// Directed bench for priority_encoder83: three parameter variants share one stimulus,
// expected {valid, code, pending} words are queued per step and checked after the edge.
module tb_priority_encoder83;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;

    logic        a   [3];
    logic        b   [3];
    logic        c   [3];
    logic        vld [3];
    logic [7:0]  pend[3];
    logic [11:0] obs [3];

    typedef struct {
        string       tag;
        int          dut;
        logic [11:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // dut 0: edge, low-first   dut 1: edge, high-first   dut 2: level, low-first
    priority_encoder83 #(.EDGE_MODE(1'b1), .LOW_FIRST(1'b1)) u_el (
        .i_CLK(clk), .i_RST(rst), .i_REQ(req), .i_MASK(mask), .i_ACK(ack),
        .o_A(a[0]), .o_B(b[0]), .o_C(c[0]), .o_VALID(vld[0]), .o_PENDING(pend[0]));
    priority_encoder83 #(.EDGE_MODE(1'b1), .LOW_FIRST(1'b0)) u_eh (
        .i_CLK(clk), .i_RST(rst), .i_REQ(req), .i_MASK(mask), .i_ACK(ack),
        .o_A(a[1]), .o_B(b[1]), .o_C(c[1]), .o_VALID(vld[1]), .o_PENDING(pend[1]));
    priority_encoder83 #(.EDGE_MODE(1'b0), .LOW_FIRST(1'b1)) u_ll (
        .i_CLK(clk), .i_RST(rst), .i_REQ(req), .i_MASK(mask), .i_ACK(ack),
        .o_A(a[2]), .o_B(b[2]), .o_C(c[2]), .o_VALID(vld[2]), .o_PENDING(pend[2]));

    assign obs[0] = {vld[0], a[0], b[0], c[0], pend[0]};
    assign obs[1] = {vld[1], a[1], b[1], c[1], pend[1]};
    assign obs[2] = {vld[2], a[2], b[2], c[2], pend[2]};

    function automatic logic [11:0] w(input logic v, input logic [2:0] code, input logic [7:0] p);
        return {v, code, p};
    endfunction

    task automatic expect_one(input int dut, input string tag, input logic [11:0] val);
        exp_t e;
        e.tag = tag;
        e.dut = dut;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_all(input string tag, input logic [11:0] val);
        for (int i = 0; i < 3; i++) expect_one(i, tag, val);
    endtask

    // Advance one edge, then retire every queued expectation against the outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            assert (obs[e.dut] === e.val)
            else begin
                bad++;
                $error("FAIL %s dut%0d observed={v=%b code=%b pend=%h} expected={v=%b code=%b pend=%h}",
                       e.tag, e.dut, obs[e.dut][11], obs[e.dut][10:8], obs[e.dut][7:0],
                       e.val[11], e.val[10:8], e.val[7:0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; mask = 8'hFF; ack = 1'b0;
        expect_all("reset", w(1'b0, 3'd0, 8'h00));
        tick();

        // Idle, then a single one-cycle pulse on bit 5.
        rst = 1'b0;
        expect_all("idle", w(1'b0, 3'd0, 8'h00));
        tick();
        req = 8'h20;
        expect_all("pulse5", w(1'b1, 3'd5, 8'h20));
        tick();
        req = 8'h00;
        expect_all("hold5", w(1'b1, 3'd5, 8'h20));
        tick();
        ack = 1'b1;
        expect_all("ack5", w(1'b0, 3'd0, 8'h00));
        tick();
        ack = 1'b0;

        // Three simultaneous requests drained in priority order.
        req = 8'h94;
        expect_one(0, "m94", w(1'b1, 3'd2, 8'h94));
        expect_one(1, "m94", w(1'b1, 3'd7, 8'h94));
        expect_one(2, "m94", w(1'b1, 3'd2, 8'h94));
        tick();
        req = 8'h00; ack = 1'b1;
        expect_one(0, "drain1", w(1'b1, 3'd4, 8'h90));
        expect_one(1, "drain1", w(1'b1, 3'd4, 8'h14));
        expect_one(2, "drain1", w(1'b1, 3'd4, 8'h90));
        tick();
        expect_one(0, "drain2", w(1'b1, 3'd7, 8'h80));
        expect_one(1, "drain2", w(1'b1, 3'd2, 8'h04));
        expect_one(2, "drain2", w(1'b1, 3'd7, 8'h80));
        tick();
        expect_all("drain3", w(1'b0, 3'd0, 8'h00));
        tick();
        ack = 1'b0;

        // A masked request latches but is not presented until unmasked.
        mask = 8'hFE; req = 8'h01;
        expect_all("masked0", w(1'b0, 3'd0, 8'h01));
        tick();
        mask = 8'hFF; req = 8'h00;
        expect_all("unmask0", w(1'b1, 3'd0, 8'h01));
        tick();
        ack = 1'b1;
        expect_all("ack0", w(1'b0, 3'd0, 8'h00));
        tick();
        ack = 1'b0;

        // ACK coinciding with a fresh edge on the presented bit: set wins.
        req = 8'h08;
        expect_all("req3", w(1'b1, 3'd3, 8'h08));
        tick();
        req = 8'h00;
        expect_all("hold3", w(1'b1, 3'd3, 8'h08));
        tick();
        req = 8'h08; ack = 1'b1;
        expect_all("setwins3", w(1'b1, 3'd3, 8'h08));
        tick();
        req = 8'h00;
        expect_all("ack3", w(1'b0, 3'd0, 8'h00));
        tick();

        // ACK while nothing is presented must not clear a masked pending bit.
        ack = 1'b0; mask = 8'h00; req = 8'h01;
        expect_all("maskall", w(1'b0, 3'd0, 8'h01));
        tick();
        ack = 1'b1; req = 8'h00;
        expect_all("ackinvalid", w(1'b0, 3'd0, 8'h01));
        tick();
        ack = 1'b0; mask = 8'hFF;
        expect_all("reveal0", w(1'b1, 3'd0, 8'h01));
        tick();
        ack = 1'b1;
        expect_all("ackrev0", w(1'b0, 3'd0, 8'h00));
        tick();
        ack = 1'b0;

        // Preemption, then masking the presented bit.
        req = 8'h80;
        expect_all("req7", w(1'b1, 3'd7, 8'h80));
        tick();
        req = 8'h01;
        expect_one(0, "preempt", w(1'b1, 3'd0, 8'h81));
        expect_one(1, "preempt", w(1'b1, 3'd7, 8'h81));
        expect_one(2, "preempt", w(1'b1, 3'd0, 8'h81));
        tick();
        mask = 8'hFE; req = 8'h00;
        expect_all("maskpresented", w(1'b1, 3'd7, 8'h81));
        tick();

        // Request held through reset release: edge mode latches once, level re-pends.
        rst = 1'b1; req = 8'h40; mask = 8'hFF;
        expect_all("midreset", w(1'b0, 3'd0, 8'h00));
        tick();
        rst = 1'b0;
        expect_all("held6", w(1'b1, 3'd6, 8'h40));
        tick();
        ack = 1'b1;
        expect_one(0, "ackheld6", w(1'b0, 3'd0, 8'h00));
        expect_one(1, "ackheld6", w(1'b0, 3'd0, 8'h00));
        expect_one(2, "ackheld6", w(1'b1, 3'd6, 8'h40));
        tick();
        ack = 1'b0;
        expect_one(0, "stillhigh6", w(1'b0, 3'd0, 8'h00));
        expect_one(2, "stillhigh6", w(1'b1, 3'd6, 8'h40));
        tick();
        req = 8'h00; ack = 1'b1;
        expect_all("drop6", w(1'b0, 3'd0, 8'h00));
        tick();
        ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
